// File: rtl/psum_accumulator.sv
// psum_accumulator: sums 8-lane signed PSUM words from the CIM unit over a
// configurable number of input-channel passes. On the last pass it applies
// ReLU, an arithmetic right shift and 4b saturation to produce 8 activations.
// Optional feature: define PSUM_ACC_BIAS_EN to add a per-lane signed bias
// (bias_in) that is latched per group and added before ReLU.
module psum_accumulator #(
  parameter int LANES  = 8,
  parameter int PSUM_W = 18,
  parameter int ACC_W  = 24,
  parameter int ACT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psum_valid,
  output logic                    psum_ready,
  input  logic [LANES*PSUM_W-1:0] psum_in,
  input  logic [4:0]              cfg_pass_num,
  input  logic [3:0]              cfg_shift,
`ifdef PSUM_ACC_BIAS_EN
  input  logic [LANES*12-1:0]     bias_in,
`endif
  output logic                    act_valid,
  input  logic                    act_ready,
  output logic [LANES*ACT_W-1:0]  act_out,
  output logic                    ovf_flag
);

  localparam int ACT_MAX = (1 << ACT_W) - 1;

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  state_t                   state_q, state_d;
  logic [4:0]               pass_cnt_q, pass_cnt_d;
  logic [4:0]               pass_num_q, pass_num_d;
  logic [3:0]               shift_q, shift_d;
  logic signed [ACC_W-1:0]  acc_q [LANES];
  logic signed [ACC_W-1:0]  acc_d [LANES];
  logic                     act_valid_q, act_valid_d;
  logic [LANES*ACT_W-1:0]   act_out_q, act_out_d;
  logic                     ovf_q, ovf_d;

  logic                     accept;
  logic                     first_c;
  logic                     final_c;
  logic                     lane_ovf;
  logic [4:0]               eff_num;
  logic [3:0]               eff_shift;
  logic signed [ACC_W-1:0]  sum_c [LANES];
  logic signed [ACC_W:0]    sum_x_c [LANES];
  logic [ACT_W-1:0]         act_c [LANES];

`ifdef PSUM_ACC_BIAS_EN
  localparam int BIAS_W = 12;
  logic [LANES*BIAS_W-1:0]  bias_q, bias_d;
  logic [BIAS_W-1:0]        bias_c [LANES];
`endif

  // Sign-extend one PSUM lane to one bit wider than the accumulator.
  function automatic logic signed [ACC_W:0] sext_psum(input logic [PSUM_W-1:0] p);
    return {{(ACC_W+1-PSUM_W){p[PSUM_W-1]}}, p};
  endfunction

  // Add a lane word to the accumulator, clamping to the signed ACC_W range.
  function automatic logic signed [ACC_W-1:0] sat_sum(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W:0]   b);
    logic signed [ACC_W:0] w;
    w = {a[ACC_W-1], a} + b;
    if (w[ACC_W] != w[ACC_W-1])
      return w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return w[ACC_W-1:0];
  endfunction

  // Report whether the same addition left the representable range.
  function automatic logic sum_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W:0]   b);
    logic signed [ACC_W:0] w;
    w = {a[ACC_W-1], a} + b;
    return w[ACC_W] != w[ACC_W-1];
  endfunction

  // ReLU, right shift and clamp to the unsigned activation range.
  function automatic logic [ACT_W-1:0] act_of(input logic signed [ACC_W:0] v,
                                              input logic [3:0]             sh);
    logic [ACC_W:0] r;
    if (v[ACC_W]) return '0;
    r = v >> sh;
    if (r > (ACC_W+1)'(ACT_MAX)) return ACT_W'(ACT_MAX);
    return r[ACT_W-1:0];
  endfunction

  // Input handshake only stalls while an unaccepted result is being held.
  assign psum_ready = !(act_valid_q && !act_ready);
  assign accept     = psum_valid && psum_ready;

  // Next-state logic: per-lane accumulate/emit datapath and the pass-counting FSM.
  always_comb begin
    state_d     = state_q;
    pass_cnt_d  = pass_cnt_q;
    pass_num_d  = pass_num_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    act_valid_d = act_valid_q;
    act_out_d   = act_out_q;
    ovf_d       = ovf_q;
`ifdef PSUM_ACC_BIAS_EN
    bias_d      = bias_q;
`endif

    first_c   = (state_q == IDLE);
    eff_num   = (cfg_pass_num == 5'd0) ? 5'd1 : cfg_pass_num;
    eff_shift = first_c ? cfg_shift : shift_q;
    lane_ovf  = 1'b0;

    for (int i = 0; i < LANES; i++) begin
      sum_c[i] = sat_sum(first_c ? '0 : acc_q[i], sext_psum(psum_in[i*PSUM_W +: PSUM_W]));
      lane_ovf = lane_ovf | sum_ovf(first_c ? '0 : acc_q[i],
                                    sext_psum(psum_in[i*PSUM_W +: PSUM_W]));
`ifdef PSUM_ACC_BIAS_EN
      bias_c[i]   = first_c ? bias_in[i*BIAS_W +: BIAS_W] : bias_q[i*BIAS_W +: BIAS_W];
      sum_x_c[i]  = {sum_c[i][ACC_W-1], sum_c[i]}
                  + {{(ACC_W+1-BIAS_W){bias_c[i][BIAS_W-1]}}, bias_c[i]};
`else
      sum_x_c[i]  = {sum_c[i][ACC_W-1], sum_c[i]};
`endif
      act_c[i] = act_of(sum_x_c[i], eff_shift);
    end

    final_c = first_c ? (eff_num == 5'd1) : (pass_cnt_q == pass_num_q - 5'd1);

    if (act_valid_q && act_ready)
      act_valid_d = 1'b0;

    if (accept) begin
      acc_d = sum_c;
      ovf_d = ovf_q | lane_ovf;
      if (first_c) begin
        pass_num_d = eff_num;
        shift_d    = cfg_shift;
`ifdef PSUM_ACC_BIAS_EN
        bias_d     = bias_in;
`endif
      end
      if (final_c) begin
        state_d     = IDLE;
        pass_cnt_d  = 5'd0;
        act_valid_d = 1'b1;
        for (int i = 0; i < LANES; i++)
          act_out_d[i*ACT_W +: ACT_W] = act_c[i];
      end else begin
        state_d    = ACCUM;
        pass_cnt_d = pass_cnt_q + 5'd1;
      end
    end
  end

  // State and output registers with synchronous reset discarding any partial group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pass_cnt_q  <= 5'd0;
      pass_num_q  <= 5'd1;
      shift_q     <= 4'd0;
      for (int i = 0; i < LANES; i++)
        acc_q[i] <= '0;
      act_valid_q <= 1'b0;
      act_out_q   <= '0;
      ovf_q       <= 1'b0;
`ifdef PSUM_ACC_BIAS_EN
      bias_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pass_cnt_q  <= pass_cnt_d;
      pass_num_q  <= pass_num_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      act_valid_q <= act_valid_d;
      act_out_q   <= act_out_d;
      ovf_q       <= ovf_d;
`ifdef PSUM_ACC_BIAS_EN
      bias_q      <= bias_d;
`endif
    end
  end

  assign act_valid = act_valid_q;
  assign act_out   = act_out_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed-vector bench for psum_accumulator.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_psum_accumulator;

  logic         clk = 1'b0;
  logic         rst;
  logic         psum_valid;
  logic         psum_ready;
  logic [143:0] psum_in;
  logic [4:0]   cfg_pass_num;
  logic [3:0]   cfg_shift;
`ifdef PSUM_ACC_BIAS_EN
  logic [95:0]  bias_in;
`endif
  logic         act_valid;
  logic         act_ready;
  logic [31:0]  act_out;
  logic         ovf_flag;

  int n_cmp  = 0;
  int n_fail = 0;
  int lane_v [8];
  int exp_v  [8];

  psum_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .psum_valid   (psum_valid),
    .psum_ready   (psum_ready),
    .psum_in      (psum_in),
    .cfg_pass_num (cfg_pass_num),
    .cfg_shift    (cfg_shift),
`ifdef PSUM_ACC_BIAS_EN
    .bias_in      (bias_in),
`endif
    .act_valid    (act_valid),
    .act_ready    (act_ready),
    .act_out      (act_out),
    .ovf_flag     (ovf_flag)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic logic [143:0] pack_psum(input int v [8]);
    logic [143:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*18 +: 18] = 18'(v[i]);
    return r;
  endfunction

  function automatic logic [31:0] pack_act(input int v [8]);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = 4'(v[i]);
    return r;
  endfunction

  task automatic set_all(input int x);
    for (int i = 0; i < 8; i++) lane_v[i] = x;
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] pn, input logic [3:0] sh);
    psum_valid   = valid;
    cfg_pass_num = pn;
    cfg_shift    = sh;
    psum_in      = pack_psum(lane_v);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Directed test sequence.
  initial begin
    rst = 1'b1;
    act_ready = 1'b1;
    set_all(0);
    applyStimulus(1'b0, 5'd0, 4'd0);
`ifdef PSUM_ACC_BIAS_EN
    bias_in = '0;
`endif
    step();
    step();
    rst = 1'b0;
    checkOutput("reset_act_valid", 32'(act_valid), 32'd0);
    checkOutput("reset_act_out", act_out, 32'd0);
    checkOutput("reset_ovf", 32'(ovf_flag), 32'd0);
    checkOutput("reset_psum_ready", 32'(psum_ready), 32'd1);

    // Single pass, shift 0, mixed signs and clamp.
    $display("[TB] single pass");
    lane_v = '{0, 1, 5, 15, 16, -1, -100, 200};
    exp_v  = '{0, 1, 5, 15, 15, 0, 0, 15};
    applyStimulus(1'b1, 5'd1, 4'd0);
    step();
    checkOutput("single_valid", 32'(act_valid), 32'd1);
    checkOutput("single_out", act_out, pack_act(exp_v));
    psum_valid = 1'b0;
    step();
    checkOutput("single_valid_drop", 32'(act_valid), 32'd0);

    // Extreme lane values with shift 4; pass_num 0 behaves as 1.
    $display("[TB] extremes");
    lane_v = '{131071, 131071, -131072, 240, 239, 0, 16, 15};
    exp_v  = '{15, 15, 0, 15, 14, 0, 1, 0};
    applyStimulus(1'b1, 5'd0, 4'd4);
    step();
    checkOutput("extreme_valid", 32'(act_valid), 32'd1);
    checkOutput("extreme_out", act_out, pack_act(exp_v));
    psum_valid = 1'b0;
    step();

    // Four passes of +40, shift 4, with a gap and cfg changes mid-group.
    $display("[TB] four passes");
    set_all(40);
    applyStimulus(1'b1, 5'd4, 4'd4);
    step();
    checkOutput("p4_after1", 32'(act_valid), 32'd0);
    applyStimulus(1'b1, 5'd1, 4'd0);
    step();
    checkOutput("p4_after2", 32'(act_valid), 32'd0);
    psum_valid = 1'b0;
    step();
    checkOutput("p4_gap", 32'(act_valid), 32'd0);
    psum_valid = 1'b1;
    step();
    checkOutput("p4_after3", 32'(act_valid), 32'd0);
    step();
    checkOutput("p4_after4_valid", 32'(act_valid), 32'd1);
    checkOutput("p4_after4_out", act_out, 32'hAAAA_AAAA);
    psum_valid = 1'b0;
    step();

    // Backpressure: result held and input stalled while act_ready is low.
    $display("[TB] backpressure");
    act_ready = 1'b0;
    set_all(7);
    applyStimulus(1'b1, 5'd1, 4'd0);
    step();
    set_all(2);
    applyStimulus(1'b1, 5'd1, 4'd0);
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_ready", 32'(psum_ready), 32'd0);
      checkOutput("bp_valid", 32'(act_valid), 32'd1);
      checkOutput("bp_out", act_out, 32'h7777_7777);
      step();
    end
    act_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(psum_ready), 32'd1);
    step();
    checkOutput("bp_next_valid", 32'(act_valid), 32'd1);
    checkOutput("bp_next_out", act_out, 32'h2222_2222);

    // Back-to-back single-pass groups with act_ready high.
    $display("[TB] back-to-back");
    for (int k = 3; k <= 5; k++) begin
      set_all(k);
      applyStimulus(1'b1, 5'd1, 4'd0);
      step();
      checkOutput("b2b_valid", 32'(act_valid), 32'd1);
      checkOutput("b2b_out", act_out, {8{4'(k)}});
    end
    psum_valid = 1'b0;
    step();
    checkOutput("b2b_end_valid", 32'(act_valid), 32'd0);

    // Reset after 2 of 4 passes, then a fresh 2-pass group.
    $display("[TB] reset mid-group");
    set_all(3);
    applyStimulus(1'b1, 5'd4, 4'd0);
    step();
    step();
    psum_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_mid_valid", 32'(act_valid), 32'd0);
    checkOutput("rst_mid_out", act_out, 32'd0);
    checkOutput("rst_mid_ready", 32'(psum_ready), 32'd1);
    set_all(5);
    applyStimulus(1'b1, 5'd2, 4'd0);
    step();
    checkOutput("fresh_after1", 32'(act_valid), 32'd0);
    step();
    checkOutput("fresh_valid", 32'(act_valid), 32'd1);
    checkOutput("fresh_out", act_out, 32'hAAAA_AAAA);
    psum_valid = 1'b0;
    step();

`ifdef PSUM_ACC_BIAS_EN
    // Bias -20 over two passes of +15, shift 1: (30-20)>>1 = 5.
    $display("[TB] bias");
    for (int i = 0; i < 8; i++) bias_in[i*12 +: 12] = 12'(-20);
    set_all(15);
    applyStimulus(1'b1, 5'd2, 4'd1);
    step();
    bias_in = '0;
    step();
    checkOutput("bias_valid", 32'(act_valid), 32'd1);
    checkOutput("bias_out", act_out, 32'h5555_5555);
    psum_valid = 1'b0;
    step();
`endif

    checkOutput("ovf_never_set", 32'(ovf_flag), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
